// File: rtl/traffic_timer.sv
// traffic_timer: start-button debounce/enable pulse plus phase tick counter; optional hold input via TRAFFIC_TIMER_HOLD_EN
module traffic_timer #(
  parameter int TICK_DIV   = 50000000,
  parameter int PRESC_W    = 26,
  parameter int CNT_MAX    = 27,
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       enable_sig,
`ifdef TRAFFIC_TIMER_HOLD_EN
  input  logic       hold,
`endif
  output logic       enable,
  output logic [4:0] counter_24,
  output logic       tick,
  output logic       cycle_done
);
  logic               s1_q, s2_q;
  logic               db_level_q, db_level_d, db_prev_q;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               enable_q, enable_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               tick_q, tick_d, done_q, done_d;
  logic               run, wrap, deb_hit;
`ifdef TRAFFIC_TIMER_HOLD_EN
  assign run = enable_sig & ~hold;
`else
  assign run = enable_sig;
`endif
  always_comb begin
    deb_hit    = (s2_q != db_level_q) && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
    deb_cnt_d  = (s2_q == db_level_q || deb_hit) ? '0 : deb_cnt_q + 1'b1;
    db_level_d = deb_hit ? s2_q : db_level_q;
    enable_d   = db_level_q & ~db_prev_q & ~enable_sig;
    wrap       = presc_q == PRESC_W'(TICK_DIV - 1);
    presc_d    = !enable_sig ? '0 : !run ? presc_q : wrap ? '0 : presc_q + 1'b1;
    cnt_d      = !enable_sig ? '0 : !(run && wrap) ? cnt_q :
                 (cnt_q == 5'(CNT_MAX)) ? '0 : cnt_q + 5'd1;
    tick_d     = run & wrap;
    done_d     = run & wrap & (cnt_q == 5'(CNT_MAX));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      deb_cnt_q  <= '0;
      enable_q   <= 1'b0;
      presc_q    <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_q       <= start_btn;
      s2_q       <= s1_q;
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      deb_cnt_q  <= deb_cnt_d;
      enable_q   <= enable_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end
  assign enable     = enable_q;
  assign counter_24 = cnt_q;
  assign tick       = tick_q;
  assign cycle_done = done_q;
endmodule
